// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register pair (32-cycle shift-add / restoring divide).
// Optional MTHI/MTLO write path enabled by defining MDU_MTHILO_EN.
module mdu_iter #(
  parameter int W     = 32,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           cancel,
`ifdef MDU_MTHILO_EN
  input  logic           mthi,
  input  logic           mtlo,
  input  logic [W-1:0]   mt_data,
`endif
  output logic           busy,
  output logic           done,
  output logic [1:0]     hilo_we,
  output logic [2*W-1:0] hilo_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN, S_DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q, sa_q, sb_q, bz_q;
  logic [W-1:0]     opnd_q;     // multiplicand |a| or divisor |b|
  logic [W-1:0]     a_raw_q;
  logic [2*W-1:0]   acc_q;      // mult: {partial, multiplier}; div: low half holds dividend/quotient
  logic [W-1:0]     rem_q;
  logic             busy_q, done_q;
  logic [1:0]       we_q;
  logic [2*W-1:0]   wdata_q;

  logic           signed_op, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] acc_mul_d, acc_div_d;
  logic [W:0]     div_shift;
  logic [W-1:0]   div_diff, rem_d;
  logic           div_ge;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;
  logic [2*W-1:0] result_d;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[W-1];
    b_neg     = signed_op & b[W-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;

    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    acc_mul_d = {mul_sum, acc_q[W-1:1]};

    // Remainder stays below the divisor, so the W-bit difference is exact whenever div_ge holds.
    div_shift = {rem_q, acc_q[W-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[W-1:0] - opnd_q;
    rem_d     = div_ge ? div_diff : div_shift[W-1:0];
    acc_div_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};

    prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quot_fix  = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix   = sa_q ? -rem_q : rem_q;

    if (!div_q)     result_d = prod_fix;
    else if (bz_q)  result_d = {a_raw_q, {W{1'b1}}};
    else            result_d = {rem_fix, quot_fix};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      opnd_q  <= '0;
      a_raw_q <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 2'b00;
      wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          we_q   <= 2'b00;
          if (cancel) begin
            busy_q <= 1'b0;
          end else if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            div_q   <= op[1];
            sa_q    <= a_neg;
            sb_q    <= b_neg;
            bz_q    <= (b == '0);
            a_raw_q <= a;
            rem_q   <= '0;
            opnd_q  <= op[1] ? b_mag : a_mag;
            acc_q   <= {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
`ifdef MDU_MTHILO_EN
          else if (mthi | mtlo) begin
            we_q    <= {mthi, mtlo};
            wdata_q <= {mt_data, mt_data};
          end
`endif
        end
        S_RUN: begin
          if (cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= div_q ? acc_div_d : acc_mul_d;
            if (div_q) rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) state_q <= S_SIGN;
          end
        end
        S_SIGN: begin
          if (cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            we_q    <= 2'b11;
            wdata_q <= result_d;
          end
        end
        default: begin
          // The write is already on the outputs here; cancel simply returns to IDLE like normal.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 2'b00;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign hilo_we    = we_q;
  assign hilo_wdata = wdata_q;

endmodule
